// File: rtl/mips_pkg.sv
// mips_pkg: shared address/instruction widths, fetch window bounds and fetch FSM encoding
package mips_pkg;
  localparam int ADDR_W = 13;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] BASE_ADDR = 13'h0940;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 13'h0D3F;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/pc_wrap_inc.sv
// pc_wrap_inc: sequential next address that wraps from the last window word back to the first
module pc_wrap_inc
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE = mips_pkg::BASE_ADDR,
  parameter logic [ADDR_W-1:0] LAST = mips_pkg::LAST_ADDR
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc
);
  assign next_pc = pc == LAST ? BASE : pc + 1'b1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with redirect/flush handling and a saturating delivery count
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = mips_pkg::BASE_ADDR,
  parameter int WINDOW_WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                inst_valid,
  output logic [INSTR_W-1:0]  inst_data,
  output logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_ready,
  output logic                fault,
  output logic [15:0]         inst_count
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + WINDOW_WORDS - 1);
  fetch_state_t state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc_inc;
  logic in_window, legal, capture;
  assign in_window = redirect_addr >= BASE_ADDR && redirect_addr <= LAST_ADDR;
  assign legal = redirect_valid && in_window;
  pc_wrap_inc #(.BASE(BASE_ADDR), .LAST(LAST_ADDR)) u_inc (.pc(pc), .next_pc(pc_inc));
  // state and pc registers
  always_ff @(posedge clk) begin
    state <= reset ? S_IDLE : state_d;
    pc    <= reset ? BASE_ADDR : pc_d;
  end
  // next state, next pc and capture decision; a legal redirect always wins the pc
  always_comb begin
    state_d = state;
    pc_d    = legal ? redirect_addr : pc;
    capture = 1'b0;
    case (state)
      S_IDLE:  state_d = stall ? S_IDLE : S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          state_d = legal ? S_IDLE : S_OUT;
          capture = !legal;
          pc_d    = legal ? redirect_addr : pc_inc;
        end else if (legal) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = imem_ack ? S_IDLE : S_FLUSH;
      S_OUT:   state_d = legal ? S_IDLE : inst_ready ? (stall ? S_IDLE : S_REQ) : S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  // state-decoded handshake outputs; REQ/FLUSH and OUT are disjoint so req and valid never overlap
  always_comb begin
    imem_req   = state == S_REQ || state == S_FLUSH;
    inst_valid = state == S_OUT;
  end
  // request address latched at request start so a redirect cannot disturb the outstanding access
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr  <= BASE_ADDR;
      inst_data  <= '0;
      inst_addr  <= BASE_ADDR;
      fault      <= 1'b0;
      inst_count <= '0;
    end else begin
      fault <= redirect_valid && !in_window;
      if (!imem_req && state_d == S_REQ) imem_addr <= pc_d;
      if (capture) begin
        inst_data <= imem_rdata;
        inst_addr <= pc;
      end
      if (inst_valid && inst_ready && inst_count != 16'hFFFF) inst_count <= inst_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: transaction-level scoreboard plus directed scenarios for fetch_ctrl
module tb_fetch_ctrl;
  localparam logic [12:0] BASE = 13'h0940;
  localparam logic [12:0] LAST = 13'h0D3F;
  typedef struct {logic [12:0] a; logic [31:0] d;} item_t;
  logic clk = 0, reset = 1, stall = 0, redirect_valid = 0, imem_ack = 0, inst_ready = 1;
  logic [12:0] redirect_addr = BASE;
  logic [31:0] imem_rdata = 0;
  logic imem_req, inst_valid, fault;
  logic [12:0] imem_addr, inst_addr;
  logic [31:0] inst_data;
  logic [15:0] inst_count;
  int checks = 0, errors = 0;
  bit ack_en = 1, force_ack = 0, armed = 0, m_rst_chk = 0, m_discard = 0, m_fault = 0;
  logic resp_prev_req = 0, prev_req = 0, prev_stall = 1;
  logic [12:0] prev_addr = 0, m_pc = BASE;
  logic [15:0] m_count = 0, base_cnt = 0;
  item_t q[$];
  logic [12:0] starts[$], deliv[$];

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .fault(fault), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] wrap(input logic [12:0] a);
    return a == LAST ? BASE : a + 13'd1;
  endfunction

  function automatic bit in_win(input logic [12:0] a);
    return a >= BASE && a <= LAST;
  endfunction

  function automatic logic [31:0] word(input logic [12:0] a);
    return {16'hC0DE, 3'b000, a};
  endfunction

  function automatic logic [12:0] at(input logic [12:0] qq[$], input int i);
    return i < qq.size() ? qq[i] : 13'h1FFF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // memory: acks one cycle after a request appears, data derived from the address
  always @(posedge clk) begin
    #2;
    imem_ack = force_ack || (ack_en && imem_req && resp_prev_req && !imem_ack);
    imem_rdata = word(imem_addr);
    resp_prev_req = imem_req;
  end

  // scoreboard: checks this cycle's outputs, then applies the events the next edge will see
  always @(negedge clk) begin
    bit legal;
    if (armed) begin
      check("req_valid_excl", 32'(imem_req && inst_valid), 0);
      if (m_rst_chk) begin
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_inst_addr", inst_addr, BASE);
        check("rst_inst_data", inst_data, 0);
      end
      check("fault", fault, m_fault);
      check("inst_count", inst_count, m_count);
      check("inst_valid", inst_valid, 32'(q.size() > 0));
      if (inst_valid && q.size() > 0) begin
        check("inst_addr", inst_addr, q[0].a);
        check("inst_data", inst_data, q[0].d);
      end
      if (imem_req && !prev_req) begin
        check("req_start_addr", imem_addr, m_pc);
        check("req_start_unstalled", prev_stall, 0);
        starts.push_back(imem_addr);
      end
      if (imem_req && prev_req) check("req_addr_hold", imem_addr, prev_addr);
      if (inst_valid && inst_ready) deliv.push_back(inst_addr);
    end
    m_rst_chk = 0;
    if (reset) begin
      armed = 1;
      m_rst_chk = 1;
      q.delete();
      m_pc = BASE;
      m_discard = 0;
      m_count = 0;
      m_fault = 0;
      prev_req = 0;
      prev_stall = stall;
    end else begin
      legal = redirect_valid && in_win(redirect_addr);
      m_fault = redirect_valid && !in_win(redirect_addr);
      if (inst_valid && inst_ready && m_count != 16'hFFFF) m_count++;
      if (inst_valid && (inst_ready || legal) && q.size() > 0) void'(q.pop_front());
      if (imem_req && imem_ack) begin
        if (!m_discard && !legal) begin
          q.push_back('{a: imem_addr, d: imem_rdata});
          m_pc = wrap(imem_addr);
        end
        m_discard = 0;
      end
      if (legal) begin
        m_pc = redirect_addr;
        if (imem_req && !imem_ack) m_discard = 1;
      end
      prev_req = imem_req;
      prev_addr = imem_addr;
      prev_stall = stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // directed scenarios with literal expectations
  initial begin
    tick;
    tick;
    reset = 0;
    starts.delete();
    deliv.delete();
    for (int i = 0; i < 60 && inst_count < 3; i++) tick;
    stall = 1;
    check("seq_count", inst_count, 3);
    check("seq_addr0", at(starts, 0), 13'h0940);
    check("seq_addr1", at(starts, 1), 13'h0941);
    check("seq_addr2", at(starts, 2), 13'h0942);
    repeat (8) tick;
    redirect_valid = 1;
    redirect_addr = 13'h0D3F;
    tick;
    redirect_valid = 0;
    deliv.delete();
    stall = 0;
    for (int i = 0; i < 60 && deliv.size() < 2; i++) tick;
    stall = 1;
    check("wrap_first", at(deliv, 0), 13'h0D3F);
    check("wrap_second", at(deliv, 1), 13'h0940);
    repeat (8) tick;
    ack_en = 0;
    redirect_valid = 1;
    redirect_addr = 13'h0945;
    tick;
    redirect_valid = 0;
    stall = 0;
    for (int i = 0; i < 20 && !imem_req; i++) tick;
    check("pend_req", imem_req, 1);
    check("pend_addr", imem_addr, 13'h0945);
    redirect_valid = 1;
    redirect_addr = 13'h0A00;
    tick;
    redirect_valid = 0;
    starts.delete();
    deliv.delete();
    repeat (3) begin
      check("flush_req", imem_req, 1);
      check("flush_addr_hold", imem_addr, 13'h0945);
      check("flush_no_valid", inst_valid, 0);
      tick;
    end
    ack_en = 1;
    for (int i = 0; i < 30 && deliv.size() < 1; i++) tick;
    stall = 1;
    check("redir_first_req", at(starts, 0), 13'h0A00);
    check("redir_first_deliv", at(deliv, 0), 13'h0A00);
    repeat (8) tick;
    redirect_valid = 1;
    redirect_addr = 13'h09AB;
    tick;
    redirect_addr = 13'h0100;
    tick;
    redirect_valid = 0;
    check("fault_low_pulse", fault, 1);
    check("fault_low_noreq", imem_req, 0);
    tick;
    check("fault_low_end", fault, 0);
    redirect_valid = 1;
    redirect_addr = 13'h0D40;
    tick;
    redirect_valid = 0;
    check("fault_high_pulse", fault, 1);
    check("fault_high_noreq", imem_req, 0);
    tick;
    check("fault_high_end", fault, 0);
    starts.delete();
    inst_ready = 0;
    stall = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick;
    stall = 1;
    check("fault_pc_kept", at(starts, 0), 13'h09AB);
    base_cnt = m_count;
    repeat (5) begin
      check("hold_valid", inst_valid, 1);
      check("hold_addr", inst_addr, 13'h09AB);
      check("hold_data", inst_data, 32'hC0DE09AB);
      check("hold_noreq", imem_req, 0);
      tick;
    end
    inst_ready = 1;
    tick;
    check("release_valid", inst_valid, 0);
    check("release_count", inst_count, base_cnt + 16'd1);
    repeat (3) tick;
    check("release_count_once", inst_count, base_cnt + 16'd1);
    ack_en = 0;
    stall = 0;
    for (int i = 0; i < 20 && !imem_req; i++) tick;
    check("rst_pending", imem_req, 1);
    reset = 1;
    stall = 1;
    tick;
    reset = 0;
    force_ack = 1;
    tick;
    force_ack = 0;
    ack_en = 1;
    check("rst2_req", imem_req, 0);
    check("rst2_valid", inst_valid, 0);
    check("rst2_imem_addr", imem_addr, 13'h0940);
    check("rst2_inst_addr", inst_addr, 13'h0940);
    check("rst2_inst_data", inst_data, 0);
    check("rst2_count", inst_count, 0);
    check("rst2_fault", fault, 0);
    starts.delete();
    deliv.delete();
    stall = 0;
    for (int i = 0; i < 30 && deliv.size() < 1; i++) tick;
    stall = 1;
    check("rst2_first_req", at(starts, 0), 13'h0940);
    check("rst2_first_deliv", at(deliv, 0), 13'h0940);
    repeat (5) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 13'h0940, first instruction address of the group window.
REQ-002 Parameter WINDOW_WORDS, default 1024, window length; LAST_ADDR = BASE_ADDR + WINDOW_WORDS - 1 (13'h0D3F).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  pipeline hold; blocks issue of new fetches.
REQ-006 redirect_valid  input  1  branch/jump request, single-cycle qualifier.
REQ-007 redirect_addr  input  13  branch/jump target.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  13  instruction memory address.
REQ-010 imem_ack  input  1  memory completion, rdata valid same cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 inst_valid  output  1  instruction presented to decode.
REQ-013 inst_data  output  32  instruction word to decode.
REQ-014 inst_addr  output  13  address of inst_data.
REQ-015 inst_ready  input  1  decode accepts instruction.
REQ-016 fault  output  1  one-cycle pulse, illegal redirect target.
REQ-017 inst_count  output  16  instructions delivered, saturating.

Function
REQ-018 The block SHALL hold a 13-bit pc register and a four-state FSM: IDLE, REQ, FLUSH, OUT.
REQ-019 Sequential next address SHALL be pc+1, except pc == LAST_ADDR SHALL yield BASE_ADDR (wrap).
REQ-020 IDLE: stall low -> REQ next cycle; stall high -> remain IDLE.
REQ-021 REQ: imem_req = 1 and imem_addr = pc, both held stable until imem_ack.
REQ-022 REQ with imem_ack and no redirect: capture imem_rdata/pc into inst_data/inst_addr, pc <= next address, -> OUT; inst_valid high the following cycle (1-cycle ack-to-valid latency).
REQ-023 REQ with redirect, no ack: pc <= redirect_addr, -> FLUSH; imem_addr keeps the old address until ack.
REQ-024 REQ with redirect and ack same cycle: returned word discarded, pc <= redirect_addr, -> IDLE.
REQ-025 FLUSH: imem_req = 1 at old address; on imem_ack discard data, -> IDLE; a further redirect in FLUSH SHALL overwrite pc.
REQ-026 OUT: inst_valid = 1, inst_data/inst_addr stable until accepted; inst_ready high -> inst_count increments, -> REQ if stall low else IDLE.
REQ-027 OUT with redirect: pc <= redirect_addr, -> IDLE; inst_ready in that cycle still counts the instruction as delivered.
REQ-028 IDLE with redirect: pc <= redirect_addr, state rules of REQ-020 unchanged.
REQ-029 stall SHALL never abort an in-flight request or drop a presented instruction.
REQ-030 redirect_addr outside [BASE_ADDR, LAST_ADDR] SHALL be ignored entirely and fault SHALL pulse high for one cycle.
REQ-031 inst_count SHALL saturate at 16'hFFFF.
REQ-032 imem_req and inst_valid SHALL never both be high in the same cycle.

Reset
REQ-033 reset SHALL force, on the next rising edge: state IDLE, pc = BASE_ADDR, imem_req = 0, imem_addr = BASE_ADDR, inst_valid = 0, inst_data = 0, inst_addr = BASE_ADDR, fault = 0, inst_count = 0.
REQ-034 reset mid-request SHALL abandon the outstanding request; an imem_ack arriving in IDLE SHALL be ignored.
REQ-035 reset SHALL take priority over redirect, ack and stall in the same cycle.

Structure
REQ-036 A shared package mips_pkg SHALL hold ADDR_W = 13, INSTR_W = 32, BASE_ADDR, LAST_ADDR and the fetch FSM state encoding.
REQ-037 The wrap incrementer SHALL be a sub-module pc_wrap_inc (combinational, pc in, next pc out), reusable by the branch unit.

Verification
REQ-038 Reset, stall low, imem_ack one cycle after each req, inst_ready tied high -> imem_addr sequence 0x940, 0x941, 0x942; inst_count = 3 after third delivery.
REQ-039 Preload pc via redirect to 0xD3F, run two fetches -> inst_addr 0xD3F then 0x940.
REQ-040 Redirect to 0xA00 while REQ waits on ack for 0x945 -> imem_addr stays 0x945 until ack, data discarded, next req at 0xA00, no inst_valid for 0x945.
REQ-041 Redirect to 0x0100 and to 0xD40 -> fault pulses one cycle each, pc and state unchanged.
REQ-042 inst_valid held with inst_ready low for 5 cycles and stall high -> inst_data/inst_addr stable, no imem_req; release -> single count increment.
REQ-043 Assert reset while REQ pending, then ack -> outputs at reset values, ack ignored, first new req at 0x940.
